// File: rtl/grid_pkg.sv
// Shared constants and state type for the grid front end and its consumer.
package grid_pkg;

    localparam int GRID_WIDTH = 16;
    localparam int GRID_DEPTH = 16;

    localparam logic [7:0] CH_ROLL  = 8'h40;
    localparam logic [7:0] CH_EMPTY = 8'h2E;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DONE  = 2'd1,
        ERROR = 2'd2
    } state_t;

endpackage

// File: rtl/grid_loader_char_decode.sv
// Combinational ASCII byte classifier; exactly one output is high for any byte.
module char_decode
    import grid_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_roll,
    output logic       is_empty,
    output logic       is_lf,
    output logic       is_cr,
    output logic       is_bad
);

    assign is_roll  = (ch == CH_ROLL);
    assign is_empty = (ch == CH_EMPTY);
    assign is_lf    = (ch == CH_LF);
    assign is_cr    = (ch == CH_CR);
    assign is_bad   = !(is_roll || is_empty || is_lf || is_cr);

endmodule

// File: rtl/grid_loader.sv
// Assembles an ASCII '@'/'.' grid stream into a DEPTH x WIDTH bit matrix.
// Define GRID_LOADER_ROLLCNT_EN to build the live '@' counter on roll_count.
//
// state | meaning
// LOAD  | accepting bytes, building rows
// DONE  | frame complete, matrix frozen until mat_ack
// ERROR | format error, held until reset
module grid_loader
    import grid_pkg::*;
#(
    parameter int WIDTH = GRID_WIDTH,
    parameter int DEPTH = GRID_DEPTH
)
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic [7:0]                          in_char,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [DEPTH-1:0][WIDTH-1:0]         mat_out,
    output logic                                mat_valid,
    input  logic                                mat_ack,
    output logic                                err,
    output logic [$clog2(DEPTH+1)-1:0]          rows,
    output logic [$clog2(WIDTH*DEPTH+1)-1:0]    roll_count
);

    localparam int RW = $clog2(DEPTH+1);
    localparam int CW = $clog2(WIDTH+1);
    localparam int NW = $clog2(WIDTH*DEPTH+1);

    state_t        state;
    logic [CW-1:0] col;
    logic          is_roll, is_empty, is_lf, is_cr, is_bad;
    logic          col_room;

    char_decode u_decode (
        .ch       (in_char),
        .is_roll  (is_roll),
        .is_empty (is_empty),
        .is_lf    (is_lf),
        .is_cr    (is_cr),
        .is_bad   (is_bad)
    );

    assign col_room = (col < CW'(WIDTH));

`ifdef GRID_LOADER_ROLLCNT_EN
    logic [NW-1:0] roll_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            roll_q <= '0;
        end else if (state == DONE && mat_ack) begin
            roll_q <= '0;
        end else if (state == LOAD && in_valid && is_roll && col_room) begin
            roll_q <= roll_q + NW'(1);
        end
    end

    assign roll_count = roll_q;
`else
    assign roll_count = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= LOAD;
            mat_out   <= '0;
            rows      <= '0;
            col       <= '0;
            mat_valid <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        case (1'b1)
                            is_roll, is_empty: begin
                                if (col_room) begin
                                    for (int r = 0; r < DEPTH; r++) begin
                                        for (int c = 0; c < WIDTH; c++) begin
                                            if (rows == RW'(r) && col == CW'(c)) begin
                                                mat_out[r][c] <= is_roll;
                                            end
                                        end
                                    end
                                    col <= col + CW'(1);
                                end else begin
                                    state    <= ERROR;
                                    err      <= 1'b1;
                                    in_ready <= 1'b0;
                                end
                            end
                            is_lf: begin
                                if (col != '0) begin
                                    rows <= rows + RW'(1);
                                    col  <= '0;
                                    if (rows == RW'(DEPTH-1)) begin
                                        state     <= DONE;
                                        mat_valid <= 1'b1;
                                        in_ready  <= 1'b0;
                                    end
                                end else begin
                                    // blank line terminates the frame early
                                    state     <= DONE;
                                    mat_valid <= 1'b1;
                                    in_ready  <= 1'b0;
                                end
                            end
                            is_cr: begin
                            end
                            is_bad: begin
                                state    <= ERROR;
                                err      <= 1'b1;
                                in_ready <= 1'b0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                DONE: begin
                    if (mat_ack) begin
                        state     <= LOAD;
                        mat_out   <= '0;
                        rows      <= '0;
                        col       <= '0;
                        mat_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                ERROR: begin
                end
                default: begin
                    state    <= ERROR;
                    err      <= 1'b1;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_loader.sv
// Randomized and directed bench for grid_loader on a 4x4 build with a text-level reference model.
module tb_grid_loader;

    localparam int W = 4;
    localparam int D = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [7:0]          in_char = 8'h00;
    logic                in_valid = 1'b0;
    logic                mat_ack = 1'b0;
    logic                in_ready;
    logic                mat_valid;
    logic                err;
    logic [D-1:0][W-1:0] mat_out;
    logic [2:0]          rows;
    logic [4:0]          roll_count;

    grid_loader #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_char    (in_char),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mat_out    (mat_out),
        .mat_valid  (mat_valid),
        .mat_ack    (mat_ack),
        .err        (err),
        .rows       (rows),
        .roll_count (roll_count)
    );

    always #5 clk = ~clk;

`ifdef GRID_LOADER_ROLLCNT_EN
    localparam bit ROLL_EN = 1'b1;
`else
    localparam bit ROLL_EN = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    // bytes accepted since the last reset or acknowledge
    byte unsigned        hist[$];
    logic [D-1:0][W-1:0] em;
    int                  er, ecnt, eph;   // eph: 0 loading, 1 frame done, 2 error
    bit                  acc;

    function automatic void recompute();
        int c;
        byte unsigned b;
        c = 0; em = '0; er = 0; ecnt = 0; eph = 0;
        foreach (hist[i]) begin
            b = hist[i];
            if (b == 8'h40 || b == 8'h2E) begin
                if (c >= W) eph = 2;
                else begin
                    if (b == 8'h40) begin
                        em[er[1:0]][c[1:0]] = 1'b1;
                        ecnt++;
                    end
                    c++;
                end
            end else if (b == 8'h0A) begin
                if (c == 0) eph = 1;
                else begin
                    er++;
                    c = 0;
                    if (er == D) eph = 1;
                end
            end else if (b != 8'h0D) begin
                eph = 2;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("mat_out", 32'(mat_out), 32'(em));
        chk("rows", 32'(rows), er);
        chk("roll_count", 32'(roll_count), ROLL_EN ? ecnt : 0);
        chk("mat_valid", 32'(mat_valid), (eph == 1) ? 1 : 0);
        chk("err", 32'(err), (eph == 2) ? 1 : 0);
        chk("in_ready", 32'(in_ready), (eph == 0) ? 1 : 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        acc = 1'b0;
        if (!reset) hist.delete();
        else if (eph == 1 && mat_ack) hist.delete();
        else if (eph == 0 && in_valid) begin
            hist.push_back(in_char);
            acc = 1'b1;
        end
        recompute();
        #1;
        check_all();
    endtask

    // mode 0: valid every cycle, 1: idle cycle before each byte, 2: random valid
    task automatic send(input byte unsigned ch, input int mode);
        int n;
        n = 0;
        do begin
            if (mode == 1 && n == 0) begin
                in_char  = 8'h58;
                in_valid = 1'b0;
                cycle();
            end
            in_char  = ch;
            in_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            n++;
        end while (!acc && n < 64);
        in_valid = 1'b0;
        chk("send_accept", 32'(acc), 1);
    endtask

    task automatic send_str(input string s, input int mode);
        for (int i = 0; i < s.len(); i++) send(s[i], mode);
    endtask

    task automatic ack();
        mat_ack = 1'b1;
        cycle();
        mat_ack = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
    endtask

    initial begin
        recompute();
        cycle();
        cycle();
        reset = 1'b1;
        cycle();

        send_str("@@.@\n.@@.\n@...\n..@@\n", 0);
        chk("f1_row0", 32'(mat_out[0]), 32'h0000_000b);
        chk("f1_row1", 32'(mat_out[1]), 32'h0000_0006);
        chk("f1_row2", 32'(mat_out[2]), 32'h0000_0001);
        chk("f1_row3", 32'(mat_out[3]), 32'h0000_000c);
        chk("f1_rows", 32'(rows), 4);
        chk("f1_valid", 32'(mat_valid), 1);
        if (ROLL_EN) chk("f1_roll", 32'(roll_count), 8);
        ack();

        send_str("@.\n\n", 0);
        chk("f2_row0", 32'(mat_out[0]), 32'h0000_0001);
        chk("f2_rows", 32'(rows), 1);
        ack();

        send_str("@@@@@", 0);
        chk("f3_err", 32'(err), 1);
        ack();
        chk("f3_err_after_ack", 32'(err), 1);
        do_reset();

        send_str("@.@.\015\n@.@.\015\n@.@.\015\n@.@.\015\n", 1);
        chk("f4_row3", 32'(mat_out[3]), 32'h0000_0005);

        in_char  = 8'h58;
        in_valid = 1'b1;
        repeat (4) cycle();
        in_valid = 1'b0;
        ack();
        send_str(".@\n@@@@\n\n", 2);
        ack();

        send_str("@.@.\n@@", 0);
        do_reset();
        send_str("..@@\n@\n.\n@@@\n", 0);
        ack();

        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < 40 && eph == 0; k++) begin
                int r;
                byte unsigned ch;
                r = $urandom_range(0, 99);
                if (r < 30) ch = 8'h40;
                else if (r < 62) ch = 8'h2E;
                else if (r < 90) ch = 8'h0A;
                else if (r < 97) ch = 8'h0D;
                else ch = 8'(8'h41 + $urandom_range(0, 25));
                send(ch, 2);
            end
            if (eph == 1) begin
                repeat ($urandom_range(0, 3)) cycle();
                ack();
            end else if (eph == 2) begin
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grid_loader.md
# grid_loader

Upstream front end for the paper-roll removal engine. It accepts the puzzle grid as a byte stream of ASCII text through a valid/ready handshake and assembles it into a DEPTH×WIDTH bit matrix. Each '@' becomes 1 (paper) and each '.' becomes 0. When the frame is complete, the block holds the matrix stable with `mat_valid` high so that `exhaustive_access` can sample it as `mat_init`. The block returns to loading only after the consumer acknowledges.

## Interface
- `WIDTH`, 16: grid columns, matching the consumer.
- `DEPTH`, 16: grid rows, matching the consumer.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_char`  in  8  ASCII byte.
- `in_valid`  in  1  `in_char` is valid.
- `in_ready`  out  1  block can accept a byte. A byte transfers when `in_valid && in_ready` at a rising edge.
- `mat_out`  out  [WIDTH-1:0] × DEPTH  assembled grid. `mat_out[r][c]` is row r, column c; column 0 is the first character of the line.
- `mat_valid`  out  1  frame complete; `mat_out` is stable.
- `mat_ack`  in  1  one-cycle pulse from the consumer; releases the frame.
- `err`  out  1  sticky format error.
- `rows`  out  $clog2(DEPTH+1)  number of rows received in the frame.
- `roll_count`  out  $clog2(WIDTH*DEPTH+1)  number of '@' characters in the frame (see Configuration).

## Operation
- States are LOAD, DONE and ERROR.
- Reset state: LOAD; all `mat_out` rows 0; `rows`=0; column counter 0; `roll_count`=0; `mat_valid`=0; `err`=0; `in_ready`=1.
- LOAD: `in_ready`=1. Each accepted byte is handled as follows:
  - 0x40 '@': if column < WIDTH, write 1 at [row][col], col++, `roll_count`++. Otherwise go to ERROR (row overflow).
  - 0x2E '.': same as '@' but writes 0 and does not count.
  - 0x0A '\n' with col > 0: ends the row. Short rows are allowed; untouched bits stay 0. `rows`++ and col←0. If `rows` reaches DEPTH, go to DONE.
  - 0x0A '\n' with col == 0 (blank line): ends the frame early and goes to DONE. Unfilled rows stay 0 and `rows` is unchanged.
  - 0x0D '\r': ignored.
  - Any other byte: go to ERROR.
- DONE: `in_ready`=0 and `mat_valid`=1. `mat_out`, `rows` and `roll_count` are frozen. On `mat_ack`, clear all state to the reset values, except `err`, and return to LOAD.
- ERROR: `in_ready`=0, `mat_valid`=0, `err`=1. Only `reset` exits this state. `mat_out` keeps the partial contents for debug.
- `mat_ack` outside DONE is ignored.
- Counters saturate by construction: column ≤ WIDTH, `rows` ≤ DEPTH, `roll_count` ≤ WIDTH*DEPTH.

## Timing
- All outputs are registered.
- A byte accepted at edge N is reflected in `mat_out`, `rows` and `roll_count` after edge N.
- After the final '\n' is accepted at edge N, `mat_valid`=1 and `in_ready`=0 from N onward. There is no extra latency cycle.
- `mat_ack` sampled at edge M: from M onward `mat_valid`=0, `in_ready`=1 and the matrix is zeroed. A byte can be accepted at M+1.
- Throughput is one byte per cycle in LOAD.
- `in_valid` low stalls the block without side effects.
- An illegal byte accepted at edge N sets `err`=1 and `in_ready`=0 from N onward.
- Reset asserted in any state, mid-row included, takes priority over every other input at that edge.

## Configuration
- `GRID_LOADER_ROLLCNT_EN` defined: the '@' counter is built and `roll_count` is live.
- `GRID_LOADER_ROLLCNT_EN` undefined: no counter register; `roll_count` is tied to 0. Everything else is identical.

## Structure
- Shared package `grid_pkg` holds:
  - ASCII constants `CH_ROLL`=8'h40, `CH_EMPTY`=8'h2E, `CH_LF`=8'h0A, `CH_CR`=8'h0D.
  - The state enum {LOAD, DONE, ERROR}.
  - Default `WIDTH` and `DEPTH`, shared with `exhaustive_access`.
- The FSM, counters and matrix write stay in one module. A sub-module `char_decode` is natural: a combinational byte classifier producing is_roll, is_empty, is_lf, is_cr and is_bad.

## Test plan
- 4×4 build (`WIDTH`=`DEPTH`=4), stream "@@.@\n.@@.\n@...\n..@@\n" -> `mat_valid`=1 after the 20th byte. Rows are 4'b1011, 4'b0110, 4'b0001, 4'b1100 (bit 0 = column 0). `rows`=4, `roll_count`=8.
- "@.\n\n" -> DONE after the blank line. Row 0 = 4'b0001, rows 1–3 = 0, `rows`=1, `roll_count`=1.
- "@@@@@" -> `err`=1 on the 5th byte and `in_ready`=0. `mat_ack` has no effect; `reset` low clears everything.
- CRLF stream "@.@.\r\n" repeated 4 times, with `in_valid` toggled every other cycle -> same result as LF-only; the stalls cause no corruption.
- In DONE, hold `in_valid`=1 with 'X' -> no transfer and no error. Pulse `mat_ack` -> matrix zeroed, `mat_valid`=0, and the next frame loads correctly.
- Assert `reset` after 2 bytes of row 1 -> all outputs at reset values on the following cycle; a fresh frame loads correctly.
